// File: rtl/count_pwm_pkg.sv
// Shared constants for count consumers: FSM state encoding and the default
// count width, which must match the upstream up-counter.
package count_pwm_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  function automatic logic state_is_on(state_t s);
    return (s == ST_RUN) || (s == ST_STOP);
  endfunction

endpackage

// File: rtl/count_pwm_if.sv
// Signal bundle between the count source / control side and count_pwm.
// COUNT_PWM_POLARITY_EN adds the pol input.
interface count_pwm_if import count_pwm_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PCNT_W = 8
) ();

  logic [WIDTH-1:0]  count_in;
  logic              en;
  logic [WIDTH-1:0]  duty_in;
  logic              duty_wr;
  logic              duty_busy;
  logic              pwm_out;
  logic              wrap_pulse;
  logic [PCNT_W-1:0] period_cnt;
  logic              active;
`ifdef COUNT_PWM_POLARITY_EN
  logic              pol;

  modport master (
    output count_in, en, duty_in, duty_wr, pol,
    input  duty_busy, pwm_out, wrap_pulse, period_cnt, active
  );

  modport slave (
    input  count_in, en, duty_in, duty_wr, pol,
    output duty_busy, pwm_out, wrap_pulse, period_cnt, active
  );
`else
  modport master (
    output count_in, en, duty_in, duty_wr,
    input  duty_busy, pwm_out, wrap_pulse, period_cnt, active
  );

  modport slave (
    input  count_in, en, duty_in, duty_wr,
    output duty_busy, pwm_out, wrap_pulse, period_cnt, active
  );
`endif

endinterface

// File: rtl/count_wrap_det.sv
// Wrap detector for a free-running count: any decrease of the count is a wrap,
// covering both MAX->0 rollover and an upstream clear of a nonzero count.
module count_wrap_det import count_pwm_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] count_in,
  output logic             wrap,
  output logic             wrap_pulse
);

  logic [WIDTH-1:0] prev_count;

  // a held count (counter parked in clear) compares equal, so it is not a wrap
  assign wrap = (count_in < prev_count);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      prev_count <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      prev_count <= count_in;
      wrap_pulse <= wrap;
    end
  end

endmodule

// File: rtl/count_pwm.sv
// Registered PWM from an upstream count with wrap-aligned start/stop, a
// double-buffered duty and a saturating period counter.
// Optional COUNT_PWM_POLARITY_EN: pol input inverts pwm_out (idle level = pol).
//
// state   | meaning
// IDLE    | output off, waiting for en
// ARM     | en seen, waiting for the next wrap to start aligned
// RUN     | generating, counting completed periods
// STOP    | en dropped, finishing the current period
module count_pwm import count_pwm_pkg::*; #(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int PCNT_W = 8
) (
  input  logic        clk,
  input  logic        clr,
  count_pwm_if.slave  bus
);

  state_t            state, state_nxt;
  logic              wrap;
  logic              pcnt_clr, pcnt_inc;
  logic              on_nxt, pwm_d;
  logic [WIDTH-1:0]  duty_active, duty_pending, duty_eff;
  logic              duty_busy, pwm_out, active;
  logic [PCNT_W-1:0] period_cnt;

  count_wrap_det #(.WIDTH(WIDTH)) u_wrap_det (
    .clk        (clk),
    .clr        (clr),
    .count_in   (bus.count_in),
    .wrap       (wrap),
    .wrap_pulse (bus.wrap_pulse)
  );

  // pending duty bypasses onto the wrap cycle so count 0 already uses it
  assign duty_eff = (wrap && duty_busy) ? duty_pending : duty_active;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      duty_active  <= '0;
      duty_pending <= '0;
      duty_busy    <= 1'b0;
    end else if (wrap && duty_busy) begin
      duty_active <= duty_pending;
      duty_busy   <= 1'b0;
    end else if (bus.duty_wr && !duty_busy) begin
      duty_pending <= bus.duty_in;
      duty_busy    <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    pcnt_clr  = 1'b0;
    pcnt_inc  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.en) begin
          state_nxt = ST_ARM;
          pcnt_clr  = 1'b1;
        end
      end
      ST_ARM: begin
        if (wrap && bus.en) state_nxt = ST_RUN;
        else if (!bus.en)   state_nxt = ST_IDLE;
      end
      ST_RUN: begin
        pcnt_inc = wrap;
        if (!bus.en) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        pcnt_inc = wrap;
        if (wrap)        state_nxt = ST_IDLE;
        else if (bus.en) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign on_nxt = state_is_on(state_nxt);

`ifdef COUNT_PWM_POLARITY_EN
  assign pwm_d = (on_nxt && (bus.count_in < duty_eff)) ^ bus.pol;
`else
  assign pwm_d = on_nxt && (bus.count_in < duty_eff);
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= ST_IDLE;
      pwm_out    <= 1'b0;
      active     <= 1'b0;
      period_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pwm_out <= pwm_d;
      active  <= on_nxt;
      if (pcnt_clr)
        period_cnt <= '0;
      else if (pcnt_inc && (period_cnt != '1))
        period_cnt <= period_cnt + 1'b1;
    end
  end

  assign bus.duty_busy  = duty_busy;
  assign bus.pwm_out    = pwm_out;
  assign bus.active     = active;
  assign bus.period_cnt = period_cnt;

endmodule

// File: tb/tb_count_pwm.sv
// Self-checking bench for count_pwm: directed sequences, a duty table and a
// randomized phase, all checked against a behavioural model every cycle.
module tb_count_pwm;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  count_pwm_if #(.WIDTH(8), .PCNT_W(8)) bus ();

  count_pwm #(.WIDTH(8), .PCNT_W(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // behavioural model: "on" = generating; it ends at a wrap that follows a
  // cycle in which en was already low
  int m_prev, m_act, m_pend, m_busy, m_on, m_armed, m_en_d, m_pcnt;
  int exp_pwm, exp_wrap, exp_active;
  int hi, wp;

  typedef struct {
    logic [7:0] duty;
    int         exp_hi;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pol_v();
`ifdef COUNT_PWM_POLARITY_EN
    return int'(bus.pol);
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_prev = 0; m_act = 0; m_pend = 0; m_busy = 0;
    m_on = 0; m_armed = 0; m_en_d = 0; m_pcnt = 0;
    exp_pwm = 0; exp_wrap = 0; exp_active = 0;
  endtask

  task automatic model_step();
    int c, w, eff, en;
    c   = int'(bus.count_in);
    en  = int'(bus.en);
    w   = (c < m_prev) ? 1 : 0;
    eff = (w != 0 && m_busy != 0) ? m_pend : m_act;
    if (w != 0 && m_busy != 0) begin
      m_act  = m_pend;
      m_busy = 0;
    end else if (bus.duty_wr && m_busy == 0) begin
      m_pend = int'(bus.duty_in);
      m_busy = 1;
    end
    if (m_on != 0) begin
      if (w != 0) m_pcnt = (m_pcnt < 255) ? m_pcnt + 1 : 255;
      if (w != 0 && m_en_d == 0) m_on = 0;
    end else if (m_armed != 0) begin
      if (w != 0 && en != 0) begin
        m_on = 1;
        m_armed = 0;
      end else if (en == 0) begin
        m_armed = 0;
      end
    end else if (en != 0) begin
      m_armed = 1;
      m_pcnt  = 0;
    end
    m_en_d     = en;
    exp_active = m_on;
    exp_wrap   = w;
    exp_pwm    = ((m_on != 0 && c < eff) ? 1 : 0) ^ pol_v();
    m_prev     = c;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    chk("pwm",    int'(bus.pwm_out),    exp_pwm);
    chk("wrap",   int'(bus.wrap_pulse), exp_wrap);
    chk("active", int'(bus.active),     exp_active);
    chk("pcnt",   int'(bus.period_cnt), m_pcnt);
    chk("busy",   int'(bus.duty_busy),  m_busy);
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      hi += int'(bus.pwm_out);
      wp += int'(bus.wrap_pulse);
      bus.count_in = bus.count_in + 8'd1;
    end
  endtask

  task automatic adv_to(input int target);
    adv((target - int'(bus.count_in)) & 255);
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      hi += int'(bus.pwm_out);
      wp += int'(bus.wrap_pulse);
    end
  endtask

  task automatic write_duty(input logic [7:0] d);
    bus.duty_in = d;
    bus.duty_wr = 1'b1;
    adv(1);
    bus.duty_wr = 1'b0;
  endtask

  initial begin
    int p0;
    vecs[0] = '{duty: 8'd0,   exp_hi: 0};
    vecs[1] = '{duty: 8'd1,   exp_hi: 1};
    vecs[2] = '{duty: 8'd255, exp_hi: 255};
    vecs[3] = '{duty: 8'd37,  exp_hi: 37};
    vecs[4] = '{duty: 8'd200, exp_hi: 200};

    bus.count_in = '0;
    bus.en       = 1'b0;
    bus.duty_in  = '0;
    bus.duty_wr  = 1'b0;
`ifdef COUNT_PWM_POLARITY_EN
    bus.pol      = 1'b0;
`endif
    model_reset();
    hi = 0; wp = 0;

    // reset
    #1 clr = 1'b1;
    #15;
    chk("rst_pwm",    int'(bus.pwm_out),    0);
    chk("rst_wrap",   int'(bus.wrap_pulse), 0);
    chk("rst_active", int'(bus.active),     0);
    chk("rst_pcnt",   int'(bus.period_cnt), 0);
    chk("rst_busy",   int'(bus.duty_busy),  0);
    clr = 1'b0;

    // free-running, disabled: one wrap pulse, no output
    hi = 0; wp = 0;
    adv(266);
    chk("idle_wraps", wp, 1);
    chk("idle_hi", hi, 0);

    // aligned start with duty 64
    write_duty(8'd64);
    adv_to(0);
    adv_to(100);
    bus.en = 1'b1;
    adv_to(0);
    chk("arm_active", int'(bus.active), 0);
    hi = 0;
    adv(256);
    chk("start_hi", hi, 64);
    adv(1);
    chk("start_pcnt", int'(bus.period_cnt), 1);

    // duty handshake: second write while busy is dropped
    adv_to(100);
    write_duty(8'd128);
    chk("hs_busy1", int'(bus.duty_busy), 1);
    write_duty(8'd200);
    chk("hs_busy2", int'(bus.duty_busy), 1);
    adv_to(0);
    hi = 0;
    adv(256);
    chk("hs_hi", hi, 128);
    chk("hs_busy_clr", int'(bus.duty_busy), 0);

    // duty table, including both limits
    foreach (vecs[k]) begin
      adv(10);
      write_duty(vecs[k].duty);
      adv_to(0);
      hi = 0;
      adv(256);
      chk($sformatf("tbl_hi_%0d", vecs[k].duty), hi, vecs[k].exp_hi);
    end

    // graceful stop at count 10 with duty 200
    adv(10);
    bus.en = 1'b0;
    p0 = m_pcnt;
    hi = 0;
    adv_to(0);
    chk("stop_hi", hi, 190);
    chk("stop_active_mid", int'(bus.active), 1);
    adv(1);
    chk("stop_pcnt", int'(bus.period_cnt), p0 + 1);
    chk("stop_active", int'(bus.active), 0);
    chk("stop_pwm", int'(bus.pwm_out), 0);
    hi = 0;
    adv(20);
    chk("stop_idle_hi", hi, 0);

    // upstream clear at count 37 counts as a wrap
    bus.en = 1'b1;
    adv_to(0);
    adv(1);
    adv_to(37);
    adv(1);
    bus.count_in = 8'd0;
    wp = 0;
    hold(5);
    chk("clr_wraps", wp, 1);
    chk("clr_pcnt", int'(bus.period_cnt), 1);

    // period counter saturation via fast 1/0 wraps
    for (int i = 0; i < 300; i++) begin
      bus.count_in = 8'd1;
      step();
      bus.count_in = 8'd0;
      step();
    end
    chk("sat_pcnt", int'(bus.period_cnt), 255);

    // asynchronous reset mid-period with a pending duty
    adv_to(50);
    write_duty(8'd77);
    chk("pre_clr_busy", int'(bus.duty_busy), 1);
    #2 clr = 1'b1;
    #1;
    chk("aclr_pwm",    int'(bus.pwm_out),    0);
    chk("aclr_wrap",   int'(bus.wrap_pulse), 0);
    chk("aclr_active", int'(bus.active),     0);
    chk("aclr_pcnt",   int'(bus.period_cnt), 0);
    chk("aclr_busy",   int'(bus.duty_busy),  0);
    #2 clr = 1'b0;
    model_reset();
    adv_to(0);
    hi = 0;
    adv(256);
    chk("aclr_lost_hi", hi, 0);
    chk("aclr_lost_busy", int'(bus.duty_busy), 0);

    // randomized phase against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) bus.en = ~bus.en;
      bus.duty_wr = ($urandom_range(0, 29) == 0);
      bus.duty_in = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        bus.count_in = 8'd0;
        hold(int'($urandom_range(1, 3)));
      end else begin
        adv(1);
      end
    end
    bus.duty_wr = 1'b0;

`ifdef COUNT_PWM_POLARITY_EN
    bus.en = 1'b0;
    adv(600);
    bus.pol = 1'b1;
    adv(1);
    chk("pol_idle", int'(bus.pwm_out), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
